i2c_bus_conditioner: RTL and testbench
======================================

# i2c_bus_conditioner

Input front end for the I2C target datapath. It takes the raw, asynchronous SCL and SDA pad levels, synchronizes them to `clk`, rejects glitches, and produces clean levels plus single-cycle SCL edge, START, STOP and SCL-stuck-low timeout events. The I2C target consumes these events instead of sampling the pins itself.

## Interface
- `FILTER_LEN`, default 3: number of consecutive synchronized cycles a new level must persist before it is accepted. Legal range is 1..15.
- `TIMEOUT_CYCLES`, default 4096: number of SCL-low cycles during a busy bus before a timeout is declared. Legal range is 2..2^20.
- `clk` in 1: system clock, the only clock.
- `rst` in 1: synchronous, active-high reset.
- `i2c_scl_i` in 1: raw SCL pad level, asynchronous.
- `i2c_sda_i` in 1: raw SDA pad level, asynchronous.
- `scl_f` out 1: filtered SCL level.
- `sda_f` out 1: filtered SDA level.
- `scl_rise` out 1: one-cycle pulse when `scl_f` goes 0→1.
- `scl_fall` out 1: one-cycle pulse when `scl_f` goes 1→0.
- `start` out 1: one-cycle pulse on a START or repeated START.
- `stop` out 1: one-cycle pulse on a STOP.
- `busy` out 1: high between a START and the next STOP or timeout.
- `timeout` out 1: one-cycle pulse when SCL has been held low too long.

## Operation
- **Synchronizer.** Each line passes through two flops, `s1` then `s2`. Both flops reset to 1, which is the idle bus level.
- **Glitch filter.** Each line has its own counter `cnt`, 4 bits wide, and filtered register `f`. On every edge:
  - If `s2 == f`: `cnt` ← 0.
  - Else if `cnt == FILTER_LEN-1`: `f` ← `s2` and `cnt` ← 0.
  - Else: `cnt` ← `cnt` + 1.
  - Any mismatch run shorter than `FILTER_LEN` cycles leaves `f` unchanged.
- **Previous-value registers.** `scl_p` and `sda_p` hold the value of `f` from the prior cycle. Both reset to 1.
- **Edge events.** These are combinational from registers only:
  - `scl_rise` = `scl_f & ~scl_p`
  - `scl_fall` = `~scl_f & scl_p`
- **START.** `start` = `~sda_f & sda_p & scl_f & scl_p`, i.e. SDA falls while SCL was and still is high.
- **STOP.** `stop` = `sda_f & ~sda_p & scl_f & scl_p`.
- **Simultaneous changes.** If SCL and SDA filtered values change in the same cycle, `start` and `stop` stay 0. The SCL edge pulse is still reported.
- **`busy` register.**
  - Set on `start`, including a repeated START while already busy.
  - Cleared on `stop` or `timeout`.
  - If `start` and `timeout` occur in the same cycle, `start` wins and `busy` stays 1.
- **Timeout counter `tcnt`** (width = clog2(TIMEOUT_CYCLES+1)):
  - Increments each cycle while `busy & ~scl_f`.
  - Clears when `scl_f` = 1 or `busy` = 0.
  - When `tcnt == TIMEOUT_CYCLES-1` and SCL is still low, `timeout` pulses for one cycle, `busy` ← 0 on that edge, and `tcnt` ← 0.
  - No further timeout occurs until the next START. This follows from `busy` = 0.
- **Reset values.**
  - `scl_f` = `sda_f` = 1.
  - `busy` = 0.
  - All counters 0.
  - Every pulse output is 0 during reset and in the cycle after it is released.
- **Reset mid-transaction.** Reset aborts the transaction: `busy` drops, and the next START is needed to set it again.

## Timing
- **Filter latency.** A stable raw change first sampled by `s1` on edge 1 appears on `f` after edge `FILTER_LEN+2`. With the default `FILTER_LEN` = 3, that is 5 cycles.
- **Event latency.** `scl_rise`, `scl_fall`, `start` and `stop` are high during exactly the one cycle following the edge that updated `f`.
- **Skew tolerance.** Relative SDA/SCL skew under `FILTER_LEN` cycles does not affect event classification, provided the level being tested (for example SCL for START) is stable.
- **Timeout pulse.** `timeout` fires `TIMEOUT_CYCLES` cycles after `scl_f` first reads 0 while `busy`.
- **Logic depth.** There is no combinational path from the pads to any output.

## Test plan
All scenarios use `FILTER_LEN` = 3 and `TIMEOUT_CYCLES` = 64.

1. **Reset values.** Hold `rst` for 3 cycles with pads at 1, then release. Expect `scl_f` = `sda_f` = 1 and `busy` = 0, with every pulse output at 0 for 10 cycles.
2. **Glitch rejection.** Drive SCL low for 2 cycles, then high. Expect no change on `scl_f` and no `scl_fall`. Then drive SCL low for 3 cycles. Expect `scl_f` = 0 on edge 5 after the drop and `scl_fall` for 1 cycle.
3. **START.** With SCL = 1, drop SDA. Expect `start` for 1 cycle, `busy` = 1, and `stop` = 0. Then toggle SCL 9 times with SDA changing only while SCL is low. Expect 9 `scl_rise` and 9 `scl_fall` pulses, and no `start` or `stop`.
4. **Repeated START and STOP.** While `busy`, drop SDA with SCL high. Expect `start` and `busy` still 1. Then raise SDA with SCL high. Expect `stop` and `busy` = 0 the next cycle.
5. **Simultaneous change.** Change SDA and SCL in the same raw cycle. Expect no `start` or `stop`, and exactly one SCL edge pulse.
6. **Timeout.** After a START, hold SCL low for 100 cycles. Expect `timeout` for 1 cycle at SCL-low cycle 64, `busy` = 0, and no second `timeout`. After SCL is released, a new START sets `busy` again.

Source files
------------

// File: rtl/i2c_bus_conditioner.sv
// I2C input front end: synchronizes and deglitches the raw SCL/SDA pads, then derives
// single-cycle SCL edge, START, STOP and SCL-stuck-low timeout events from registered levels.
module i2c_bus_conditioner #(
  parameter int unsigned FILTER_LEN     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic i2c_scl_i,
  input  logic i2c_sda_i,
  output logic scl_f,
  output logic sda_f,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic busy,
  output logic timeout
);

  localparam int unsigned TcntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0] FiltLast = 4'(FILTER_LEN - 1);
  localparam logic [TcntW-1:0] TcntLast = TcntW'(TIMEOUT_CYCLES - 1);

  // Bit 0 carries SCL, bit 1 carries SDA through the synchronizer and filter.
  logic [1:0] pad_raw;
  logic [1:0] s1_q, s2_q;
  logic [1:0] f_vec, p_vec;

  assign pad_raw = {i2c_sda_i, i2c_scl_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 2'b11;
      s2_q <= 2'b11;
    end else begin
      s1_q <= pad_raw;
      s2_q <= s1_q;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_filt
    logic [3:0] cnt_q, cnt_d;
    logic       f_q, f_d;
    logic       p_q;

    always_comb begin
      cnt_d = cnt_q;
      f_d   = f_q;
      if (s2_q[i] == f_q) begin
        cnt_d = '0;
      end else if (cnt_q == FiltLast) begin
        f_d   = s2_q[i];
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
        f_q   <= 1'b1;
        p_q   <= 1'b1;
      end else begin
        cnt_q <= cnt_d;
        f_q   <= f_d;
        p_q   <= f_q;
      end
    end

    assign f_vec[i] = f_q;
    assign p_vec[i] = p_q;
  end

  logic scl_p, sda_p;
  logic rise_raw, fall_raw, start_raw, stop_raw, timeout_raw;

  assign scl_f = f_vec[0];
  assign sda_f = f_vec[1];
  assign scl_p = p_vec[0];
  assign sda_p = p_vec[1];

  // Requiring SCL high on both sides of the SDA edge suppresses START/STOP when
  // both lines change in the same cycle.
  assign rise_raw  = scl_f & ~scl_p;
  assign fall_raw  = ~scl_f & scl_p;
  assign start_raw = ~sda_f & sda_p & scl_f & scl_p;
  assign stop_raw  = sda_f & ~sda_p & scl_f & scl_p;

  logic             busy_q, busy_d;
  logic [TcntW-1:0] tcnt_q, tcnt_d;

  assign timeout_raw = busy_q & ~scl_f & (tcnt_q == TcntLast);

  always_comb begin
    busy_d = busy_q;
    if (start_raw) begin
      busy_d = 1'b1;
    end else if (stop_raw || timeout_raw) begin
      busy_d = 1'b0;
    end
  end

  always_comb begin
    tcnt_d = tcnt_q;
    if (!busy_q || scl_f) begin
      tcnt_d = '0;
    end else if (tcnt_q == TcntLast) begin
      tcnt_d = '0;
    end else begin
      tcnt_d = tcnt_q + TcntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      tcnt_q <= '0;
    end else begin
      busy_q <= busy_d;
      tcnt_q <= tcnt_d;
    end
  end

  // Pulses are masked while reset is held so stale state never leaks out.
  assign scl_rise = rise_raw & ~rst;
  assign scl_fall = fall_raw & ~rst;
  assign start    = start_raw & ~rst;
  assign stop     = stop_raw & ~rst;
  assign timeout  = timeout_raw & ~rst;
  assign busy     = busy_q;

  a_edge_excl : assert property (@(posedge clk) disable iff (rst) !(scl_rise && scl_fall));
  a_cond_excl : assert property (@(posedge clk) disable iff (rst) !(start && stop));

endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// Directed bench for i2c_bus_conditioner with FILTER_LEN=3 and TIMEOUT_CYCLES=64.
module tb_i2c_bus_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic sda = 1'b1;
  logic scl_f, sda_f, scl_rise, scl_fall, start, stop, busy, timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int n_rise = 0, n_fall = 0, n_start = 0, n_stop = 0, n_timeout = 0;

  i2c_bus_conditioner #(
    .FILTER_LEN    (3),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i2c_scl_i(scl),
    .i2c_sda_i(sda),
    .scl_f    (scl_f),
    .sda_f    (sda_f),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop),
    .busy     (busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (scl_rise === 1'b1) n_rise++;
    if (scl_fall === 1'b1) n_fall++;
    if (start === 1'b1) n_start++;
    if (stop === 1'b1) n_stop++;
    if (timeout === 1'b1) n_timeout++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_rise = 0; n_fall = 0; n_start = 0; n_stop = 0; n_timeout = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; scl = 1'b1; sda = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      n_tests++;
      if ({scl_rise, scl_fall, start, stop, timeout} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_pulses_during: got %b want 00000",
                 {scl_rise, scl_fall, start, stop, timeout});
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if ({scl_f, sda_f, busy, scl_rise, scl_fall, start, stop, timeout} !== 8'b1100_0000) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: got %b want 11000000", i,
                 {scl_f, sda_f, busy, scl_rise, scl_fall, start, stop, timeout});
      end
      tick(1);
    end
  endtask

  task automatic test_glitch();
    clear_counts();
    scl = 1'b0; tick(2); scl = 1'b1; tick(8);
    n_tests++;
    if (scl_f !== 1'b1) begin
      n_fail++; $display("FAIL glitch_scl_f: got %b want 1", scl_f);
    end
    n_tests++;
    if (n_fall !== 0) begin
      n_fail++; $display("FAIL glitch_no_fall: got %0d want 0", n_fall);
    end
    clear_counts();
    scl = 1'b0; tick(3); scl = 1'b1; tick(1);
    n_tests++;
    if (scl_f !== 1'b1) begin
      n_fail++; $display("FAIL filt_edge4: got %b want 1", scl_f);
    end
    tick(1);
    n_tests++;
    if ({scl_f, scl_fall} !== 2'b01) begin
      n_fail++; $display("FAIL filt_edge5: got %b want 01", {scl_f, scl_fall});
    end
    tick(1);
    n_tests++;
    if (scl_fall !== 1'b0) begin
      n_fail++; $display("FAIL filt_fall_width: got %b want 0", scl_fall);
    end
    tick(8);
    n_tests++;
    if ({scl_f, 8'(n_fall), 8'(n_rise)} !== {1'b1, 8'd1, 8'd1}) begin
      n_fail++;
      $display("FAIL filt_recover: got scl_f=%b fall=%0d rise=%0d want 1/1/1",
               scl_f, n_fall, n_rise);
    end
  endtask

  task automatic test_start();
    logic [8:0] bits = 9'b1_0100_1100;
    clear_counts();
    sda = 1'b0; tick(4);
    n_tests++;
    if (start !== 1'b0) begin
      n_fail++; $display("FAIL start_early: got %b want 0", start);
    end
    tick(1);
    n_tests++;
    if ({start, stop} !== 2'b10) begin
      n_fail++; $display("FAIL start_pulse: got start/stop=%b want 10", {start, stop});
    end
    tick(1);
    n_tests++;
    if ({start, busy} !== 2'b01) begin
      n_fail++; $display("FAIL start_busy: got start/busy=%b want 01", {start, busy});
    end
    clear_counts();
    for (int i = 8; i >= 0; i--) begin
      scl = 1'b0; tick(6);
      sda = bits[i]; tick(6);
      scl = 1'b1; tick(6);
    end
    n_tests++;
    if (n_rise !== 9 || n_fall !== 9) begin
      n_fail++; $display("FAIL byte_edges: got rise=%0d fall=%0d want 9/9", n_rise, n_fall);
    end
    n_tests++;
    if (n_start !== 0 || n_stop !== 0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL byte_no_cond: got start=%0d stop=%0d busy=%b want 0/0/1",
               n_start, n_stop, busy);
    end
  endtask

  task automatic test_rstart_stop();
    scl = 1'b0; tick(6); sda = 1'b1; tick(6); scl = 1'b1; tick(6);
    clear_counts();
    sda = 1'b0; tick(5);
    n_tests++;
    if ({start, busy} !== 2'b11) begin
      n_fail++; $display("FAIL rstart_pulse: got start/busy=%b want 11", {start, busy});
    end
    tick(1);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL rstart_busy: got %b want 1", busy);
    end
    sda = 1'b1; tick(4);
    n_tests++;
    if (stop !== 1'b0) begin
      n_fail++; $display("FAIL stop_early: got %b want 0", stop);
    end
    tick(1);
    n_tests++;
    if ({stop, start, busy} !== 3'b101) begin
      n_fail++; $display("FAIL stop_pulse: got stop/start/busy=%b want 101", {stop, start, busy});
    end
    tick(1);
    n_tests++;
    if ({stop, busy} !== 2'b00) begin
      n_fail++; $display("FAIL stop_busy: got stop/busy=%b want 00", {stop, busy});
    end
  endtask

  task automatic test_simultaneous();
    clear_counts();
    scl = 1'b0; sda = 1'b0; tick(10);
    n_tests++;
    if (n_start !== 0 || n_stop !== 0 || n_fall !== 1 || n_rise !== 0) begin
      n_fail++;
      $display("FAIL simul_fall: got start=%0d stop=%0d fall=%0d rise=%0d want 0/0/1/0",
               n_start, n_stop, n_fall, n_rise);
    end
    clear_counts();
    scl = 1'b1; sda = 1'b1; tick(10);
    n_tests++;
    if (n_start !== 0 || n_stop !== 0 || n_rise !== 1 || n_fall !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_rise: got start=%0d stop=%0d rise=%0d fall=%0d busy=%b want 0/0/1/0/0",
               n_start, n_stop, n_rise, n_fall, busy);
    end
  endtask

  task automatic test_timeout();
    sda = 1'b0; tick(6);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL to_setup_busy: got %b want 1", busy);
    end
    clear_counts();
    scl = 1'b0; tick(67);
    n_tests++;
    if ({timeout, busy} !== 2'b01) begin
      n_fail++; $display("FAIL to_cycle63: got timeout/busy=%b want 01", {timeout, busy});
    end
    tick(1);
    n_tests++;
    if ({timeout, busy} !== 2'b11) begin
      n_fail++; $display("FAIL to_cycle64: got timeout/busy=%b want 11", {timeout, busy});
    end
    tick(1);
    n_tests++;
    if ({timeout, busy} !== 2'b00) begin
      n_fail++; $display("FAIL to_after: got timeout/busy=%b want 00", {timeout, busy});
    end
    tick(31);
    n_tests++;
    if (n_timeout !== 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL to_single: got count=%0d busy=%b want 1/0", n_timeout, busy);
    end
    scl = 1'b1; tick(8);
    sda = 1'b1; tick(8);
    clear_counts();
    sda = 1'b0; tick(5);
    n_tests++;
    if (start !== 1'b1) begin
      n_fail++; $display("FAIL to_restart_pulse: got %b want 1", start);
    end
    tick(1);
    n_tests++;
    if (busy !== 1'b1 || n_timeout !== 0) begin
      n_fail++; $display("FAIL to_restart_busy: got busy=%b to=%0d want 1/0", busy, n_timeout);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; sda = 1'b1; tick(1);
    n_tests++;
    if ({busy, start, stop} !== 3'b000) begin
      n_fail++; $display("FAIL rstmid_abort: got busy/start/stop=%b want 000", {busy, start, stop});
    end
    tick(1);
    rst = 1'b0;
    clear_counts();
    tick(10);
    n_tests++;
    if (busy !== 1'b0 || n_start !== 0 || n_stop !== 0 || sda_f !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_idle: got busy=%b start=%0d stop=%0d sda_f=%b want 0/0/0/1",
               busy, n_start, n_stop, sda_f);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_start();
    test_rstart_stop();
    test_simultaneous();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
